// File: rtl/phase_sequencer.sv
// Phase sequencer: steps through NPHASES phases, each lasting a programmable number of
// 1 us ticks, optionally looping. Define PHASE_SEQUENCER_PAUSE_EN to add a pause input.
module phase_sequencer #(
    parameter int CLOCK_SPEED_MHZ = 12,
    parameter int NPHASES         = 4,
    parameter int DUR_WIDTH       = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       loop_en,
`ifdef PHASE_SEQUENCER_PAUSE_EN
    input  logic                       pause,
`endif
    input  logic                       dur_wr_en,
    input  logic [$clog2(NPHASES)-1:0] dur_wr_idx,
    input  logic [DUR_WIDTH-1:0]       dur_wr_data,
    output logic                       busy,
    output logic [$clog2(NPHASES)-1:0] phase,
    output logic [NPHASES-1:0]         phase_en,
    output logic                       phase_done,
    output logic                       seq_done
);

    localparam int PW = $clog2(NPHASES);
    localparam int SW = (CLOCK_SPEED_MHZ > 1) ? $clog2(CLOCK_SPEED_MHZ) : 1;
    localparam logic [SW-1:0] PRESC_LAST = SW'(CLOCK_SPEED_MHZ - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(NPHASES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DUR_WIDTH-1:0] dur_tbl [NPHASES];
    logic [SW-1:0]        presc_q;
    logic [SW-1:0]        presc_d;
    logic [DUR_WIDTH-1:0] cnt_q;
    logic [DUR_WIDTH-1:0] cnt_d;
    logic [PW-1:0]        phase_d;
    logic [PW-1:0]        phase_nxt;
    logic [NPHASES-1:0]   phase_en_d;
    logic                 busy_d;
    logic                 phase_done_d;
    logic                 seq_done_d;
    logic                 hold;
    logic                 tick;
    logic                 phase_end;
    logic                 last_phase;
    logic                 go;

`ifdef PHASE_SEQUENCER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // A zero duration would never expire in the down-counter, so it runs as one tick.
    function automatic logic [DUR_WIDTH-1:0] eff_dur(input logic [DUR_WIDTH-1:0] d);
        return (d == '0) ? DUR_WIDTH'(1) : d;
    endfunction

    assign tick       = (presc_q == PRESC_LAST);
    assign phase_end  = tick && (cnt_q == DUR_WIDTH'(1));
    assign last_phase = (phase == PHASE_LAST);
    assign phase_nxt  = phase + 1'b1;
    assign go         = start && !abort && !hold;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!hold && phase_end && last_phase && !loop_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and the timing datapath. While held,
    // the done pulses stay low so a pulse is never stretched across a pause.
    always_comb begin
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        phase_d      = phase;
        phase_done_d = 1'b0;
        seq_done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    presc_d = '0;
                    cnt_d   = eff_dur(dur_tbl[0]);
                    phase_d = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    presc_d = '0;
                    cnt_d   = '0;
                    phase_d = '0;
                end else if (!hold) begin
                    if (!tick) begin
                        presc_d = presc_q + 1'b1;
                    end else begin
                        presc_d = '0;
                        if (!phase_end) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            phase_done_d = 1'b1;
                            if (last_phase) begin
                                seq_done_d = 1'b1;
                                phase_d    = '0;
                                cnt_d      = loop_en ? eff_dur(dur_tbl[0]) : '0;
                            end else begin
                                phase_d = phase_nxt;
                                cnt_d   = eff_dur(dur_tbl[phase_nxt]);
                            end
                        end
                    end
                end
            end
            default: begin
                presc_d = '0;
                cnt_d   = '0;
                phase_d = '0;
            end
        endcase
        busy_d     = (state_d == S_RUN);
        phase_en_d = busy_d ? (NPHASES'(1) << phase_d) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            phase      <= '0;
            phase_en   <= '0;
            busy       <= 1'b0;
            phase_done <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            phase      <= phase_d;
            phase_en   <= phase_en_d;
            busy       <= busy_d;
            phase_done <= phase_done_d;
            seq_done   <= seq_done_d;
        end
    end

    // A write landing on the entry being latched this edge is seen only by later entries.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NPHASES; i++) begin
                dur_tbl[i] <= DUR_WIDTH'(1);
            end
        end else if (dur_wr_en && (int'(dur_wr_idx) < NPHASES)) begin
            dur_tbl[dur_wr_idx] <= dur_wr_data;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: vector table of timed scenarios, hand-written corner cases and
// randomized runs checked cycle by cycle against a schedule-based reference model.
module tb_phase_sequencer;

    localparam int C  = 12;
    localparam int NP = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          loop_en;
    logic          dur_wr_en;
    logic [1:0]    dur_wr_idx;
    logic [DW-1:0] dur_wr_data;
    logic          busy;
    logic [1:0]    phase;
    logic [NP-1:0] phase_en;
    logic          phase_done;
    logic          seq_done;
`ifdef PHASE_SEQUENCER_PAUSE_EN
    logic          pause;
`endif

    phase_sequencer #(.CLOCK_SPEED_MHZ(C), .NPHASES(NP), .DUR_WIDTH(DW)) dut (
        .CLK        (clk),
        .RST        (rst),
        .start      (start),
        .abort      (abort),
        .loop_en    (loop_en),
`ifdef PHASE_SEQUENCER_PAUSE_EN
        .pause      (pause),
`endif
        .dur_wr_en  (dur_wr_en),
        .dur_wr_idx (dur_wr_idx),
        .dur_wr_data(dur_wr_data),
        .busy       (busy),
        .phase      (phase),
        .phase_en   (phase_en),
        .phase_done (phase_done),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic [1:0] phase;
        logic [3:0] phase_en;
        logic       pd;
        logic       sd;
    } outs_t;

    typedef struct {
        int tab[4];
        int mtab[4];
        int mtab2[4];
        bit lp;
        int abort_at;
        int rst_at;
        int restart_at;
        int ncyc;
        int pd[6];
        int sd;
        int w_cyc[3];
        int w_idx[3];
        int w_dat[3];
        bit ev;
    } vec_t;

    int          cyc;
    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q[$];
    vec_t        vecs[5];

    int m_tab[4];
    int m_start;
    int m_abort;
    bit m_loop;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got busy/phase/en/pd/sd=%b expected %b", name, cyc, act, exp);
    endtask

    // Reference: outputs follow from the elapsed time since the sequence was entered,
    // laid against the cumulative phase lengths in cycles.
    function automatic outs_t model(input int t);
        outs_t o;
        int    e, p, acc;
        int    dk[4];
        o = '0;
        if (t <= m_start) return o;
        if (m_abort >= 0 && t > m_abort) return o;
        p = 0;
        for (int k = 0; k < 4; k++) begin
            dk[k] = (m_tab[k] == 0 ? 1 : m_tab[k]) * C;
            p += dk[k];
        end
        e = t - m_start - 1;
        if (e >= p && !m_loop) begin
            if (e == p) begin
                o.pd = 1'b1;
                o.sd = 1'b1;
            end
            return o;
        end
        if (e > 0 && e % p == 0) begin
            o.pd = 1'b1;
            o.sd = 1'b1;
        end
        e = e % p;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (e >= acc && e < acc + dk[k]) begin
                o.phase = 2'(k);
                if (e == acc && k > 0) o.pd = 1'b1;
            end
            acc += dk[k];
        end
        o.busy     = 1'b1;
        o.phase_en = 4'(1) << o.phase;
        return o;
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input bit lp, input int ncyc, input int sd);
        vec_t v;
        v.tab        = '{a, b, c, d};
        v.mtab       = v.tab;
        v.mtab2      = v.tab;
        v.lp         = lp;
        v.abort_at   = -1;
        v.rst_at     = -1;
        v.restart_at = -1;
        v.ncyc       = ncyc;
        v.pd         = '{-1, -1, -1, -1, -1, -1};
        v.sd         = sd;
        v.w_cyc      = '{-1, -1, -1};
        v.w_idx      = '{0, 0, 0};
        v.w_dat      = '{0, 0, 0};
        v.ev         = 1'b1;
        return v;
    endfunction

    task automatic reset_dut();
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        dur_wr_en = 1'b0; dur_wr_idx = '0; dur_wr_data = '0;
`ifdef PHASE_SEQUENCER_PAUSE_EN
        pause = 1'b0;
`endif
        tick();
        rst = 1'b0;
    endtask

    task automatic load_table(input int tab[4]);
        for (int k = 0; k < 4; k++) begin
            dur_wr_en = 1'b1; dur_wr_idx = 2'(k); dur_wr_data = DW'(tab[k]);
            tick();
        end
        dur_wr_en = 1'b0;
    endtask

    task automatic drive(input vec_t v, input bit rnd);
        outs_t now;
        now = model(cyc);
        if (cyc == v.restart_at) begin
            m_start = cyc;
            m_abort = -1;
            m_tab   = v.mtab2;
        end
        start = (cyc == 0) || (cyc == v.restart_at) || (rnd && now.busy && $urandom_range(0, 7) == 0);
        abort = (cyc == v.abort_at) || (rnd && cyc > 0 && !now.busy && $urandom_range(0, 7) == 0);
        rst   = (cyc == v.rst_at);
        dur_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (v.w_cyc[i] == cyc) begin
                dur_wr_en = 1'b1; dur_wr_idx = 2'(v.w_idx[i]); dur_wr_data = DW'(v.w_dat[i]);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input bit rnd, input string tag);
        int sd_seen;
        reset_dut();
        load_table(v.tab);
        m_tab   = v.mtab;
        m_start = 0;
        m_abort = (v.abort_at >= 0) ? v.abort_at : v.rst_at;
        m_loop  = v.lp;
        exp_q.delete();
        for (int i = 0; i < 6; i++) if (v.pd[i] >= 0) exp_q.push_back(32'(v.pd[i]));
        sd_seen = -1;
        cyc = 0;
        loop_en = v.lp;
        drive(v, rnd);
        for (int t = 1; t <= v.ncyc; t++) begin
            tick();
            check_outs({tag, " outputs"}, {busy, phase, phase_en, phase_done, seq_done}, model(cyc));
            if (v.ev && phase_done) begin
                if (exp_q.size() == 0) check({tag, " extra phase_done"}, cyc, -1);
                else check({tag, " phase_done cycle"}, cyc, int'(exp_q.pop_front()));
            end
            if (seq_done && sd_seen < 0) sd_seen = cyc;
            drive(v, rnd);
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; dur_wr_en = 1'b0;
        if (v.ev) begin
            check({tag, " first seq_done cycle"}, sd_seen, v.sd);
            check({tag, " missing phase_done count"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   p;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;

        vecs[0] = mk(2, 1, 3, 1, 1'b0, 100, 85);
        vecs[0].pd = '{25, 37, 73, 85, -1, -1};
        vecs[1] = mk(2, 1, 3, 1, 1'b1, 110, 85);
        vecs[1].pd = '{25, 37, 73, 85, 109, -1};
        vecs[2] = mk(2, 1, 3, 1, 1'b0, 70, -1);
        vecs[2].abort_at = 30; vecs[2].restart_at = 40;
        vecs[2].pd = '{25, 65, -1, -1, -1, -1};
        vecs[3] = mk(0, 0, 0, 0, 1'b0, 60, 49);
        vecs[3].pd = '{13, 25, 37, 49, -1, -1};
        vecs[4] = mk(2, 1, 3, 1, 1'b0, 75, 70);
        vecs[4].rst_at = 20; vecs[4].restart_at = 21;
        vecs[4].mtab2 = '{1, 1, 1, 1};
        vecs[4].w_cyc = '{20, -1, -1}; vecs[4].w_idx = '{0, 0, 0}; vecs[4].w_dat = '{9, 0, 0};
        vecs[4].pd = '{34, 46, 58, 70, -1, -1};

        // Reset state.
        reset_dut();
        tick();
        check("reset busy", int'(busy), 0);
        check("reset phase", int'(phase), 0);
        check("reset phase_en", int'(phase_en), 0);
        check("reset phase_done", int'(phase_done), 0);
        check("reset seq_done", int'(seq_done), 0);

        // Abort together with start in idle, then abort alone in idle: nothing starts.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0;
        check("start+abort busy", int'(busy), 0);
        tick();
        abort = 1'b0;
        check("idle abort busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Table writes during a run: entry 1 written on its latch edge keeps the old value,
        // entry 2 written earlier takes effect, entry 0 rewritten after entry is ignored.
        v = mk(1, 1, 1, 1, 1'b0, 70, 61);
        v.mtab  = '{1, 1, 2, 1}; v.mtab2 = v.mtab;
        v.w_cyc = '{5, 12, 11}; v.w_idx = '{0, 1, 2}; v.w_dat = '{5, 3, 2};
        v.pd    = '{13, 25, 49, 61, -1, -1};
        run_vec(v, 1'b0, "runtime write");

        for (int r = 0; r < 16; r++) begin
            v = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 0, -1);
            p = 0;
            for (int k = 0; k < 4; k++) p += (v.tab[k] == 0 ? 1 : v.tab[k]) * C;
            if ($urandom_range(0, 1) == 1) v.abort_at = int'($urandom_range(1, p + 10));
            v.ncyc = v.lp ? 2 * p + 10 : p + 15;
            v.ev = 1'b0;
            run_vec(v, 1'b1, $sformatf("rand%0d", r));
        end

`ifdef PHASE_SEQUENCER_PAUSE_EN
        begin
            int pd_exp[4] = '{35, 47, 83, 95};
            int n_pd = 0;
            int sd_at = -1;
            reset_dut();
            load_table('{2, 1, 3, 1});
            cyc = 0; start = 1'b1;
            for (int t = 1; t <= 100; t++) begin
                tick();
                start = 1'b0;
                pause = (cyc >= 10 && cyc <= 19);
                if (phase_done) begin
                    if (n_pd < 4) check("pause phase_done cycle", cyc, pd_exp[n_pd]);
                    else check("pause extra phase_done", cyc, -1);
                    n_pd++;
                end
                if (seq_done && sd_at < 0) begin
                    sd_at = cyc;
                    check("pause busy at seq_done", int'(busy), 0);
                end
            end
            pause = 1'b0;
            check("pause seq_done cycle", sd_at, 95);
            check("pause phase_done count", n_pd, 4);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
